// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, FIFO entry layout and PC helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES   = 4;
    localparam int DEFAULT_DEPTH = 4;
    localparam int ENTRY_W       = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'(INSTR_BYTES - 1);
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries.
// Head is read straight from registered storage, so a push is visible next cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               valid_o,
    output logic [CW-1:0]      count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q, wr_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i & (count_q != CW'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request, prefetch FIFO,
// redirect handling with a discard state for in-flight stale reads.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  redir_pc;
    logic         push;
    logic         pop;
    logic         space;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    fetch_entry_t wentry;
    fetch_entry_t hentry;

    assign redir_pc = align_pc(redirect_pc);
    assign pop      = inst_valid & inst_ready;
    assign push     = (state_q == ST_WAIT) & mem_ack & ~redirect;

    // Occupancy once this cycle's push/pop land; a new request needs a free slot.
    assign count_after = count + CW'(push) - CW'(pop);
    assign space       = count_after < CW'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    state_d    = ST_WAIT;
                    req_addr_d = redir_pc;
                    fetch_pc_d = next_pc(redir_pc);
                end else if (space) begin
                    state_d    = ST_WAIT;
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = next_pc(fetch_pc_q);
                end
            end
            ST_WAIT: begin
                if (redirect && mem_ack) begin
                    req_addr_d = redir_pc;
                    fetch_pc_d = next_pc(redir_pc);
                end else if (redirect) begin
                    state_d    = ST_DISCARD;
                    fetch_pc_d = redir_pc;
                end else if (mem_ack && space) begin
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = next_pc(fetch_pc_q);
                end else if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect) fetch_pc_d = redir_pc;
                if (mem_ack)  state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign wentry.pc   = req_addr_q;
    assign wentry.data = mem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i (wentry),
        .rdata_o (hentry),
        .valid_o (inst_valid),
        .count_o (count)
    );

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_addr  = req_addr_q;
    assign inst_data = hentry.data;
    assign inst_pc   = hentry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/backpressure,
// hand sequences for redirect, discard and reset corner cases.
module tb_fetch_unit;

    localparam logic [31:0] OFF = 32'hFFFF_FFF8;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req1, ack1, v1;
    logic [31:0] addr1, rd1, d1, pc1;
    logic        req2, ack2, v2;
    logic [31:0] addr2, rd2, d2, pc2;

    logic auto1;
    logic man_ack;
    logic a1_q, a2_q;

    int checks = 0;
    int errors = 0;
    vec_t tv[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign rd1 = mem_word(addr1);
    assign rd2 = mem_word(addr2);

    // Memory answers one cycle after it sees a fresh request.
    always_ff @(posedge clk) begin
        if (reset) begin
            a1_q <= 1'b0;
            a2_q <= 1'b0;
        end else begin
            a1_q <= req1 & ~a1_q;
            a2_q <= req2 & ~a2_q;
        end
    end

    assign ack1 = auto1 ? a1_q : man_ack;
    assign ack2 = a2_q;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(req1), .mem_addr(addr1),
        .mem_ack(ack1), .mem_rdata(rd1),
        .inst_valid(v1), .inst_ready(inst_ready),
        .inst_data(d1), .inst_pc(pc1),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(OFF)) dut2 (
        .clk(clk), .reset(reset),
        .mem_req(req2), .mem_addr(addr2),
        .mem_ack(ack2), .mem_rdata(rd2),
        .inst_valid(v2), .inst_ready(inst_ready),
        .inst_data(d2), .inst_pc(pc2),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic ack);
        reset       = r;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        man_ack     = ack;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.req = req;
        t.addr = addr; t.v = v; t.pc = pc;
        return t;
    endfunction

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; man_ack = 1'b0; auto1 = 1'b1;

        // streaming with ready=1
        tv.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tv.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h04, 1, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h04, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h08, 1, 32'h04));
        tv.push_back(mk(0, 1, 1, 32'h08, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h0C, 1, 32'h08));
        tv.push_back(mk(0, 1, 1, 32'h0C, 0, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h10, 1, 32'h0C));
        // backpressure until full, then release
        tv.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tv.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h00, 0, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h04, 1, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h04, 1, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h08, 1, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h08, 1, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h0C, 1, 32'h00));
        tv.push_back(mk(0, 0, 1, 32'h0C, 1, 32'h00));
        tv.push_back(mk(0, 0, 0, 32'h0C, 1, 32'h00));
        tv.push_back(mk(0, 0, 0, 32'h0C, 1, 32'h00));
        tv.push_back(mk(0, 1, 1, 32'h10, 1, 32'h04));
        tv.push_back(mk(0, 1, 1, 32'h10, 1, 32'h08));
        tv.push_back(mk(0, 1, 1, 32'h14, 1, 32'h0C));
        tv.push_back(mk(0, 1, 1, 32'h14, 1, 32'h10));
        tv.push_back(mk(0, 1, 1, 32'h18, 1, 32'h14));

        for (int i = 0; i < tv.size(); i++) begin
            reset      = tv[i].rst;
            inst_ready = tv[i].rdy;
            redirect   = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req", i), 32'(req1), 32'(tv[i].req));
            chk($sformatf("v%0d addr", i), addr1, tv[i].addr);
            chk($sformatf("v%0d valid", i), 32'(v1), 32'(tv[i].v));
            chk($sformatf("v%0d req2", i), 32'(req2), 32'(tv[i].req));
            chk($sformatf("v%0d addr2", i), addr2, tv[i].addr + OFF);
            chk($sformatf("v%0d valid2", i), 32'(v2), 32'(tv[i].v));
            if (tv[i].rst) begin
                chk($sformatf("v%0d rst pc", i), pc1, 32'h0);
                chk($sformatf("v%0d rst data", i), d1, 32'h0);
                chk($sformatf("v%0d rst pc2", i), pc2, 32'h0);
            end else if (tv[i].v) begin
                chk($sformatf("v%0d pc", i), pc1, tv[i].pc);
                chk($sformatf("v%0d data", i), d1, mem_word(tv[i].pc));
                chk($sformatf("v%0d pc2", i), pc2, tv[i].pc + OFF);
                chk($sformatf("v%0d data2", i), d2,
                    mem_word(tv[i].pc + OFF));
            end
        end

        // redirect to 0x103 while waiting on addr 8
        auto1 = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("r1 addr0", addr1, 32'h0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("r1 addr8", addr1, 32'h8);
        chk("r1 pc4", pc1, 32'h4);
        cyc(0, 1, 1, 32'h0000_0103, 0);
        chk("r1 flush valid", 32'(v1), 32'h0);
        chk("r1 hold req", 32'(req1), 32'h1);
        chk("r1 hold addr", addr1, 32'h8);
        cyc(0, 1, 0, 0, 0);
        chk("r1 discard addr", addr1, 32'h8);
        cyc(0, 1, 0, 0, 1);
        chk("r1 dropped valid", 32'(v1), 32'h0);
        chk("r1 idle req", 32'(req1), 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("r1 new req", 32'(req1), 32'h1);
        chk("r1 new addr", addr1, 32'h100);
        cyc(0, 1, 0, 0, 1);
        chk("r1 first valid", 32'(v1), 32'h1);
        chk("r1 first pc", pc1, 32'h100);
        chk("r1 first data", d1, mem_word(32'h100));
        chk("r1 next addr", addr1, 32'h104);

        // redirect + ack + pop in the same cycle with two entries queued
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("r2 pre valid", 32'(v1), 32'h1);
        chk("r2 pre addr", addr1, 32'h8);
        cyc(0, 1, 1, 32'h40, 1);
        chk("r2 flush valid", 32'(v1), 32'h0);
        chk("r2 req", 32'(req1), 32'h1);
        chk("r2 addr", addr1, 32'h40);
        cyc(0, 1, 0, 0, 1);
        chk("r2 pc", pc1, 32'h40);
        chk("r2 addr next", addr1, 32'h44);

        // second redirect while discarding replaces the target
        cyc(0, 1, 1, 32'h80, 0);
        chk("r3 flush valid", 32'(v1), 32'h0);
        cyc(0, 1, 1, 32'h200, 0);
        chk("r3 held addr", addr1, 32'h44);
        cyc(0, 1, 0, 0, 1);
        chk("r3 idle req", 32'(req1), 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("r3 new addr", addr1, 32'h200);

        // reset with a request outstanding, late ack ignored
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("r4 req", 32'(req1), 32'h1);
        cyc(1, 0, 0, 0, 0);
        chk("r4 rst req", 32'(req1), 32'h0);
        cyc(0, 0, 0, 0, 1);
        chk("r4 ack ignored valid", 32'(v1), 32'h0);
        chk("r4 reissue req", 32'(req1), 32'h1);
        chk("r4 reissue addr", addr1, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("r4 no push", 32'(v1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  32  word-aligned fetch address.
REQ-008 mem_ack  input  1  read-data-valid strobe for the outstanding request.
REQ-009 mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-010 inst_valid  output  1  FIFO head holds an instruction for the datapath.
REQ-011 inst_ready  input  1  datapath accepts head this cycle.
REQ-012 inst_data  output  32  head instruction word.
REQ-013 inst_pc  output  32  address of head instruction.
REQ-014 redirect  input  1  taken branch/jump: flush and refetch.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).

Function
REQ-016 SHALL keep at most one memory request outstanding.
REQ-017 SHALL hold mem_req=1 and mem_addr stable from issue until the cycle mem_ack=1.
REQ-018 SHALL issue a request only when count + outstanding < DEPTH, so an ack never meets a full FIFO.
REQ-019 SHALL push {fetch_pc, mem_rdata} on a non-discarded ack and advance fetch_pc by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 SHALL issue the next request in the cycle after the ack when space allows; mem_req SHALL be 0 in the ack cycle+1 only if REQ-018 forbids issue.
REQ-021 SHALL present pushed data at inst_valid/inst_data/inst_pc one cycle after the ack (registered FIFO, no bypass).
REQ-022 SHALL pop the head when inst_valid & inst_ready; inst_data/inst_pc stable while inst_valid & !inst_ready.
REQ-023 SHALL support push and pop in the same cycle at any occupancy, count unchanged.
REQ-024 State machine: IDLE (no request), WAIT (request outstanding, data kept), DISCARD (request outstanding, data dropped).
REQ-025 Transitions: IDLE->WAIT on issue; WAIT->IDLE on ack with no re-issue, WAIT->WAIT on ack with re-issue; WAIT->DISCARD on redirect without ack; DISCARD->IDLE on ack; IDLE->WAIT on redirect with request to redirect_pc next cycle.
REQ-026 On redirect SHALL empty the FIFO (inst_valid=0 next cycle) and load fetch_pc={redirect_pc[31:2],2'b00}.
REQ-027 A pop coinciding with redirect SHALL count as accepted; no entry survives.
REQ-028 Redirect coinciding with ack SHALL discard that ack's data; request to redirect_pc issued next cycle.
REQ-029 Redirect while in DISCARD SHALL update fetch_pc only; remain in DISCARD until ack.
REQ-030 mem_ack in IDLE SHALL be ignored.

Reset
REQ-031 On reset SHALL set state=IDLE, count=0, FIFO pointers=0, fetch_pc=RESET_PC, mem_req=0, inst_valid=0, mem_addr=RESET_PC, inst_data=0, inst_pc=0.
REQ-032 SHALL assert mem_req with mem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-033 Reset mid-request SHALL drop the outstanding request; an ack arriving after reset SHALL be ignored.

Structure
REQ-034 Shared package fetch_pkg SHALL hold fetch state encoding (IDLE/WAIT/DISCARD), INSTR_BYTES=4, default DEPTH.
REQ-035 FIFO SHALL be one sub-module fetch_fifo (push, pop, flush, count, 64-bit entry); control FSM and fetch_pc in fetch_unit.

Verification
REQ-036 Reset release, memory acks 1 cycle after req, inst_ready=1 -> inst_pc 0,4,8,12 consecutive, one instruction per 2 cycles, mem_addr follows.
REQ-037 inst_ready=0, DEPTH=4 -> exactly 4 requests (0..12), mem_req=0 with count=4; release ready -> fetch resumes at 16.
REQ-038 Redirect to 32'h0000_0103 while WAIT on addr 8 -> addr 8 held until ack, data dropped, next mem_addr=32'h0000_0100, first inst_pc=32'h100.
REQ-039 Redirect with ack same cycle, FIFO 2 entries, pop same cycle -> inst_valid=0 next cycle, next req addr=redirect_pc.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Reset asserted with request outstanding, ack arrives next cycle -> no push, inst_valid=0, new req to RESET_PC.
